// File: rtl/depac_pkg.sv
// depac_pkg: shared types, field bounds and the packet-to-word strip helper
// for the depac_arb ingress scheduler.
package depac_pkg;

  localparam int WIDTH       = 32;
  localparam int OUTPUTWIDTH = 26;

  localparam int TYPE_HI    = 31;
  localparam int TYPE_LO    = 30;
  localparam int ADDR_HI    = 29;
  localparam int ADDR_LO    = 24;
  localparam int PAYLOAD_HI = 23;
  localparam int PAYLOAD_LO = 0;

  typedef logic [WIDTH-1:0]       pkt_t;
  typedef logic [OUTPUTWIDTH-1:0] fu_word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Drop the destination address and keep {type, payload} for the function unit.
  function automatic fu_word_t strip(pkt_t p);
    return {p[TYPE_HI:TYPE_LO], p[PAYLOAD_HI:PAYLOAD_LO]};
  endfunction

endpackage

// File: rtl/depac_arb_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick. Scans req starting at
// ptr, wrapping modulo NREQ; the first set bit wins. The pointer register
// lives in the parent so this block stays stateless.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PTRW-1:0] win
);

  logic found;

  // Walk the requesters in priority order from ptr and grant the first one found.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PTRW'(idx);
      end
    end
  end

endmodule

// File: rtl/depac_arb.sv
// depac_arb: round-robin ingress scheduler feeding one depacketize path into
// a one-entry valid/ready output register for the function unit.
// Optional feature: define ADDR_FILTER_EN to discard packets whose
// destination address differs from PE_ID (counted in drop_cnt).
module depac_arb #(
  parameter int        WIDTH       = 32,
  parameter int        OUTPUTWIDTH = 26,
  parameter int        NREQ        = 2,
  parameter logic [5:0] PE_ID      = 6'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*WIDTH-1:0]    in_data,
  output logic [NREQ-1:0]          in_ready,
  output logic                     out_valid,
  output logic [OUTPUTWIDTH-1:0]   out_data,
  input  logic                     out_ready,
  output logic [15:0]              drop_cnt
);

  import depac_pkg::*;

  localparam int PTRW = $clog2(NREQ);

  out_state_t       state_q, state_d;
  fu_word_t         data_q, data_d;
  logic [PTRW-1:0]  rr_q, rr_d;
  logic [NREQ-1:0]  gnt;
  logic [PTRW-1:0]  win;
  pkt_t             win_pkt;
  logic             can_load;
  logic             accept;
  logic             load;

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_arbiter (
    .req (in_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .win (win)
  );

  // The register can take a word when empty or when the current one drains this cycle.
  always_comb begin
    can_load = (state_q == EMPTY) | out_ready;
    in_ready = reset ? '0 : (gnt & {NREQ{can_load}});
    accept   = |in_ready;
  end

  // Select the winning packet; only the data path looks at in_data.
  always_comb begin
    win_pkt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) win_pkt = in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef ADDR_FILTER_EN
  logic [15:0] drop_q, drop_d;

  // Only packets addressed to this PE are loaded; others are consumed and counted.
  always_comb begin
    load   = accept & (win_pkt[ADDR_HI:ADDR_LO] == PE_ID);
    drop_d = drop_q;
    if (accept && !load && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // Saturating drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_cfg;

  // Without filtering every accepted packet is loaded and nothing is dropped.
  always_comb begin
    load = accept;
  end

  assign unused_cfg = ^PE_ID;
  assign drop_cnt   = '0;
`endif

  // Output register next state, held word and priority pointer update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rr_d    = rr_q;
    if (accept) begin
      if (int'(win) == NREQ - 1) rr_d = '0;
      else                       rr_d = win + 1'b1;
    end
    if (load) begin
      data_d  = strip(win_pkt);
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State, data and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

endmodule
